inst_fetch_axi_bridge: RTL and testbench
========================================

Name: inst_fetch_axi_bridge

Overview:
- Responder side of the fetch interface: accepts the PC from the fetch stage, fetches one 32-bit instruction word over an AXI4 read channel and returns it with a `complete` qualifier.
- Sits between the fetch stage and the AXI crossbar, where the instruction cache will later sit.
- Deasserts `complete` while a fetch is outstanding, so the fetch stage stalls.
- Handles flushes that arrive during an in-flight read without violating AXI ordering rules.

Parameters:
- ID_W, 4, width of arid/rid.
- AXI_ID, 0, constant ID driven on arid; rid is ignored for matching (single outstanding read).
- RESET_PC, 32'hbfc00000, reset address held on fetch_addr; used only for the reset value of last_addr.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch stage requests the word at fetch_addr (level)
- fetch_addr  in  32  virtual PC to fetch
- fetch_ack  in  1  fetch stage consumed the returned word (its ready && complete && write-enable)
- fetch_cancel  in  1  flush (exception, branch or eret); the result of the current fetch must be discarded
- inst_out  out  32  returned instruction word
- complete  out  1  inst_out/inst_bus_err valid; fetch stage may advance
- inst_bus_err  out  1  rresp was SLVERR/DECERR for this word
- arid  out  ID_W  = AXI_ID
- araddr  out  32  physical address
- arlen  out  8  = 0
- arsize  out  3  = 3'b010
- arburst  out  2  = 2'b01
- arvalid  out  1  read address valid
- arready  in  1  read address accepted
- rid  in  ID_W  read data ID (ignored)
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  last beat of the read
- rvalid  in  1  read data valid
- rready  out  1  read data accept

Behaviour:
- Reset: state=IDLE; arvalid=0, rready=0, complete=0, inst_out=0, inst_bus_err=0, discard=0, araddr=0.
- Address map, applied when the request is accepted:
  - kseg0/kseg1 (va[31:30]==2'b10): pa = {3'b000, va[28:0]}.
  - All other addresses pass through unchanged.
- FSM states: IDLE, AR, R, DONE.
- IDLE:
  - fetch_req && !fetch_cancel && fetch_addr[1:0]==0: latch araddr, go to AR; arvalid is 1 from the next cycle.
  - fetch_req && fetch_addr[1:0]!=0: no bus access; go to DONE with inst_out=0 and inst_bus_err=0. The fetch stage raises AdEL itself.
  - fetch_cancel in IDLE: ignored (nothing outstanding).
- AR:
  - arvalid=1 and araddr stable until arready; arvalid must not drop before the handshake, even on cancel.
  - On arvalid && arready: go to R.
- R:
  - rready=1.
  - On rvalid && rlast:
    - discard (or fetch_cancel in the same cycle) set: go to IDLE, clear discard, complete stays 0.
    - Otherwise: inst_out<=rdata, inst_bus_err<=(rresp[1]==1), go to DONE.
- DONE:
  - complete=1, holding inst_out/inst_bus_err stable.
  - On fetch_ack or fetch_cancel: complete=0 next cycle, go to IDLE.
  - fetch_ack with fetch_req on the next cycle starts a new read; minimum request-to-complete latency is 3 cycles (IDLE→AR→R→DONE with arready and rvalid both immediate).
- discard flag:
  - Set by fetch_cancel while in AR or R.
  - Cleared on the terminating R beat.
  - Guarantees that a flushed word never raises complete.
- Cancel in the same cycle as the arready handshake: discard is set and the read still completes on the bus.
- rvalid without rlast on a single-beat read: treated as a protocol error; the beat is accepted and the FSM stays in R until rlast.
- Reset mid-read: all state cleared immediately. The interconnect is reset alongside, so no outstanding beat is drained.
- Only one outstanding transaction at a time; AR is never issued while in R or DONE.

Decomposition:
- Shared cpu package:
  - FSM state encoding (IDLE=2'd0, AR=2'd1, R=2'd2, DONE=2'd3).
  - AXI constants: AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_* codes.
  - Reset vector 32'hbfc00000.
- Sub-module: `va_to_pa` (combinational kseg0/kseg1 mapper), to be reused by the data-side bridge.

Test Plan:
- Reset, fetch_req=1 at 0xbfc00000 with arready=1 and rdata=0x3c1d0000 on the next cycle → araddr=0x1fc00000, arlen=0, arsize=2, complete=1 with inst_out=0x3c1d0000 three cycles after the request.
- arready held low 5 cycles → arvalid stays 1 and araddr stays stable the whole time; complete remains 0 until after the R beat.
- fetch_cancel pulsed while in R, rdata=0xdeadbeef → complete never asserts; FSM returns to IDLE; next fetch at 0xbfc00380 returns its own word only.
- fetch_addr=0xbfc00002 → no arvalid; complete=1 next cycle with inst_out=0 and inst_bus_err=0.
- rresp=2'b11 on the beat → complete=1 and inst_bus_err=1.
- Back-to-back: fetch_ack in DONE with fetch_req held and fetch_addr=0xbfc00004 → new AR issued with araddr=0x1fc00004; no duplicate complete.

Source files
------------

// File: rtl/inst_fetch_axi_bridge_pkg.sv
// Shared definitions for the instruction-fetch AXI bridge: FSM encoding,
// AXI constants and the reset vector.
package inst_fetch_axi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } fetch_state_e;

  localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
  localparam logic [31:0] RESET_VECTOR    = 32'hbfc00000;

  // SLVERR and DECERR both have the upper response bit set.
  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/inst_fetch_axi_bridge_va_to_pa.sv
// Combinational kseg0/kseg1 virtual-to-physical mapper; everything outside
// the unmapped kernel segments passes through unchanged.
module va_to_pa (
  input  logic [31:0] va,
  output logic [31:0] pa
);

  // Strip the segment bits for kseg0/kseg1.
  always_comb begin
    if (va[31:30] == 2'b10) begin
      pa = {3'b000, va[28:0]};
    end else begin
      pa = va;
    end
  end

endmodule

// File: rtl/inst_fetch_axi_bridge.sv
// Responder for the fetch stage: one single-beat AXI4 read per request,
// with flush handling that lets in-flight reads finish on the bus.
module inst_fetch_axi_bridge
  import inst_fetch_axi_bridge_pkg::*;
#(
  parameter int                 ID_W     = 4,
  parameter logic [ID_W-1:0]    AXI_ID   = {ID_W{1'b0}},
  parameter logic [31:0]        RESET_PC = RESET_VECTOR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [31:0]     fetch_addr,
  input  logic            fetch_ack,
  input  logic            fetch_cancel,
  output logic [31:0]     inst_out,
  output logic            complete,
  output logic            inst_bus_err,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
);

  fetch_state_e state_r, state_s;
  logic         discard_r, discard_s;
  logic         load_addr_s, load_data_s, clear_data_s;
  logic [31:0]  pa_s;
  logic [31:0]  araddr_r, inst_out_r, last_addr_r;
  logic         arvalid_r, rready_r, complete_r, inst_bus_err_r;
  logic         unused_s;

  va_to_pa u_va_to_pa (
    .va (fetch_addr),
    .pa (pa_s)
  );

  // Next-state, discard tracking and datapath load enables.
  always_comb begin
    state_s      = state_r;
    discard_s    = discard_r;
    load_addr_s  = 1'b0;
    load_data_s  = 1'b0;
    clear_data_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_req && (fetch_addr[1:0] != 2'b00)) begin
          // Misaligned PC: no bus access, the fetch stage raises AdEL.
          state_s      = DONE;
          clear_data_s = 1'b1;
        end else if (fetch_req && !fetch_cancel) begin
          state_s     = AR;
          load_addr_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      AR: begin
        if (fetch_cancel) begin
          discard_s = 1'b1;
        end else begin
          discard_s = discard_r;
        end
        if (arvalid_r && arready) begin
          state_s = R;
        end else begin
          state_s = AR;
        end
      end
      R: begin
        if (rvalid && rlast) begin
          discard_s = 1'b0;
          if (discard_r || fetch_cancel) begin
            state_s = IDLE;
          end else begin
            state_s     = DONE;
            load_data_s = 1'b1;
          end
        end else if (fetch_cancel) begin
          discard_s = 1'b1;
        end else begin
          discard_s = discard_r;
        end
      end
      DONE: begin
        if (fetch_ack || fetch_cancel) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s   = IDLE;
        discard_s = 1'b0;
      end
    endcase
  end

  // State, handshake outputs and returned word, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      discard_r      <= 1'b0;
      arvalid_r      <= 1'b0;
      rready_r       <= 1'b0;
      complete_r     <= 1'b0;
      araddr_r       <= 32'd0;
      inst_out_r     <= 32'd0;
      inst_bus_err_r <= 1'b0;
      last_addr_r    <= RESET_PC;
    end else begin
      state_r    <= state_s;
      discard_r  <= discard_s;
      arvalid_r  <= (state_s == AR);
      rready_r   <= (state_s == R);
      complete_r <= (state_s == DONE);
      if (load_addr_s) begin
        araddr_r    <= pa_s;
        last_addr_r <= fetch_addr;
      end
      if (load_data_s) begin
        inst_out_r     <= rdata;
        inst_bus_err_r <= axi_resp_is_err(rresp);
      end else if (clear_data_s) begin
        inst_out_r     <= 32'd0;
        inst_bus_err_r <= 1'b0;
      end
    end
  end

  assign unused_s     = ^{rid, last_addr_r};

  assign arid         = AXI_ID;
  assign araddr       = araddr_r;
  assign arlen        = 8'd0;
  assign arsize       = AXI_SIZE_4B;
  assign arburst      = AXI_BURST_INCR;
  assign arvalid      = arvalid_r;
  assign rready       = rready_r;
  assign complete     = complete_r;
  assign inst_out     = inst_out_r;
  assign inst_bus_err = inst_bus_err_r;

endmodule

// File: tb/tb_inst_fetch_axi_bridge.sv
// Randomized bench for inst_fetch_axi_bridge: the bench plays fetch stage and
// AXI slave, and predicts each transaction's outcome at transaction level.
module tb_inst_fetch_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, fetch_ack, fetch_cancel;
  logic [31:0] fetch_addr;
  logic [31:0] inst_out;
  logic        complete, inst_bus_err;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  inst_fetch_axi_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .fetch_cancel (fetch_cancel),
    .inst_out     (inst_out),
    .complete     (complete),
    .inst_bus_err (inst_bus_err),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unmapped kernel segments fold down to the low 512 MB.
  function automatic logic [31:0] exp_pa(input logic [31:0] va);
    if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
    else if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
    else return va;
  endfunction

  // One fetch from request to retirement. Bus latency is ar_dly extra AR
  // cycles, r_dly idle R cycles and 'extra' non-last beats; cancel_at is the
  // in-flight cycle index of a flush (-1 for none).
  task automatic do_fetch(input logic [31:0] va, input int ar_dly, input int r_dly,
                          input int extra, input logic [1:0] resp, input logic [31:0] data,
                          input int cancel_at, input int hold, input bit end_cancel,
                          input bit chain, input logic [31:0] chain_va);
    int          flight;
    logic [31:0] exp_data;
    logic        exp_err;
    fetch_req  = 1'b1;
    fetch_addr = va;
    tick();
    fetch_req = 1'b0;
    if (va[1:0] != 2'b00) begin
      exp_data = 32'd0;
      exp_err  = 1'b0;
      check_val("misaligned_no_arvalid", {31'd0, arvalid}, 32'd0);
    end else begin
      exp_data = data;
      exp_err  = resp[1];
      flight   = ar_dly + 1 + r_dly + extra + 1;
      for (int i = 0; i < flight; i++) begin
        check_val("busy_complete", {31'd0, complete}, 32'd0);
        if (i <= ar_dly) begin
          check_val("ar_arvalid", {31'd0, arvalid}, 32'd1);
          check_val("ar_araddr", araddr, exp_pa(va));
          check_val("ar_rready", {31'd0, rready}, 32'd0);
          arready = (i == ar_dly);
          rvalid  = 1'b0;
          rlast   = 1'b0;
        end else begin
          check_val("r_arvalid", {31'd0, arvalid}, 32'd0);
          check_val("r_rready", {31'd0, rready}, 32'd1);
          arready = 1'b0;
          if (i > ar_dly + r_dly) begin
            rvalid = 1'b1;
            rlast  = (i == flight - 1);
            rdata  = rlast ? data : $urandom;
            rresp  = rlast ? resp : 2'b00;
            rid    = 4'($urandom);
          end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
          end
        end
        fetch_cancel = (i == cancel_at);
        tick();
      end
      arready      = 1'b0;
      rvalid       = 1'b0;
      rlast        = 1'b0;
      fetch_cancel = 1'b0;
      if (cancel_at >= 0 && cancel_at < flight) begin
        for (int k = 0; k < 2; k++) begin
          check_val("flushed_complete", {31'd0, complete}, 32'd0);
          check_val("flushed_arvalid", {31'd0, arvalid}, 32'd0);
          if (k == 0) tick();
        end
        return;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      check_val("done_complete", {31'd0, complete}, 32'd1);
      check_val("done_inst_out", inst_out, exp_data);
      check_val("done_bus_err", {31'd0, inst_bus_err}, {31'd0, exp_err});
      if (h < hold) tick();
    end
    if (end_cancel) fetch_cancel = 1'b1;
    else fetch_ack = 1'b1;
    if (chain) begin
      fetch_req  = 1'b1;
      fetch_addr = chain_va;
    end
    tick();
    fetch_ack    = 1'b0;
    fetch_cancel = 1'b0;
    check_val("retire_complete", {31'd0, complete}, 32'd0);
    check_val("retire_arvalid", {31'd0, arvalid}, 32'd0);
  endtask

  initial begin
    logic [31:0] va;
    logic [31:0] seg_base [4];
    int          ar_dly, r_dly, extra, cancel_at, flight;
    seg_base[0] = 32'h0000_0000;
    seg_base[1] = 32'h8000_0000;
    seg_base[2] = 32'hA000_0000;
    seg_base[3] = 32'hC000_0000;

    reset = 1'b1; fetch_req = 1'b0; fetch_ack = 1'b0; fetch_cancel = 1'b0;
    fetch_addr = 32'd0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rdata = 32'd0; rresp = 2'b00; rid = 4'd0;
    repeat (3) tick();
    check_val("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check_val("rst_rready", {31'd0, rready}, 32'd0);
    check_val("rst_complete", {31'd0, complete}, 32'd0);
    check_val("rst_inst_out", inst_out, 32'd0);
    check_val("rst_bus_err", {31'd0, inst_bus_err}, 32'd0);
    check_val("rst_araddr", araddr, 32'd0);
    check_val("arlen", {24'd0, arlen}, 32'd0);
    check_val("arsize", {29'd0, arsize}, 32'd2);
    check_val("arburst", {30'd0, arburst}, 32'd1);
    check_val("arid", {28'd0, arid}, 32'd0);
    reset = 1'b0;
    tick();

    // Directed scenarios: reset vector, slow arready, flush in R, misaligned
    // PC, error response, back-to-back fetch.
    do_fetch(32'hbfc00000, 0, 0, 0, 2'b00, 32'h3c1d0000, -1, 0, 1'b0, 1'b0, 32'd0);
    do_fetch(32'hbfc00010, 5, 0, 0, 2'b00, 32'h24080001, -1, 1, 1'b0, 1'b0, 32'd0);
    do_fetch(32'hbfc00100, 0, 2, 0, 2'b00, 32'hdeadbeef, 2, 0, 1'b0, 1'b0, 32'd0);
    do_fetch(32'hbfc00380, 0, 0, 0, 2'b00, 32'h12345678, -1, 0, 1'b0, 1'b0, 32'd0);
    do_fetch(32'hbfc00002, 0, 0, 0, 2'b00, 32'h0, -1, 0, 1'b0, 1'b0, 32'd0);
    do_fetch(32'hbfc00020, 1, 1, 0, 2'b11, 32'h8c090000, -1, 0, 1'b0, 1'b0, 32'd0);
    do_fetch(32'hbfc00000, 0, 0, 0, 2'b00, 32'h11111111, -1, 0, 1'b0, 1'b1, 32'hbfc00004);
    do_fetch(32'hbfc00004, 0, 0, 0, 2'b00, 32'h22222222, -1, 0, 1'b0, 1'b0, 32'd0);
    do_fetch(32'hbfc00040, 0, 0, 0, 2'b00, 32'h33333333, 0, 0, 1'b0, 1'b0, 32'd0);
    do_fetch(32'hbfc00044, 0, 0, 0, 2'b00, 32'h44444444, -1, 0, 1'b0, 1'b0, 32'd0);

    // Reset while a read is outstanding.
    fetch_req = 1'b1; fetch_addr = 32'h8000_1000;
    tick();
    fetch_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0; reset = 1'b1;
    tick();
    check_val("midrst_arvalid", {31'd0, arvalid}, 32'd0);
    check_val("midrst_rready", {31'd0, rready}, 32'd0);
    check_val("midrst_araddr", araddr, 32'd0);
    check_val("midrst_complete", {31'd0, complete}, 32'd0);
    reset = 1'b0;
    tick();

    for (int n = 0; n < 80; n++) begin
      va = seg_base[$urandom_range(0, 3)] + ($urandom & 32'h1fff_fffc);
      if ($urandom_range(0, 7) == 0) va[1:0] = 2'($urandom_range(1, 3));
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      extra  = $urandom_range(0, 1);
      flight = ar_dly + 1 + r_dly + extra + 1;
      cancel_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, flight - 1) : -1;
      do_fetch(va, ar_dly, r_dly, extra, 2'($urandom), $urandom, cancel_at,
               $urandom_range(0, 2), ($urandom_range(0, 4) == 0), 1'b0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
